// File: rtl/armleocpu_axi_read_arbiter_if.sv
// armleocpu_axi_read_arbiter_if: AXI read address/data channel bundle.
// master drives AR and accepts R; slave accepts AR and drives R.
interface armleocpu_axi_read_arbiter_if #(
    parameter int ADDR_WIDTH = 34,
    parameter int DATA_WIDTH = 32
);
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [1:0]            arburst;
    logic                  rvalid;
    logic                  rready;
    logic [1:0]            rresp;
    logic                  rlast;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output arvalid, araddr, arlen, arburst, rready,
        input  arready, rvalid, rresp, rlast, rdata
    );

    modport slave (
        input  arvalid, araddr, arlen, arburst, rready,
        output arready, rvalid, rresp, rlast, rdata
    );
endinterface

// File: rtl/armleocpu_axi_read_arbiter.sv
// armleocpu_axi_read_arbiter: shares one AXI read port between the PTW (u0) and
// cache refill (u1), one transaction in flight, round-robin on simultaneous requests.
module armleocpu_axi_read_arbiter (
    input  logic                                clk,
    input  logic                                rst_n,
    armleocpu_axi_read_arbiter_if.slave         u0,
    armleocpu_axi_read_arbiter_if.slave         u1,
    armleocpu_axi_read_arbiter_if.master        axi
);
    typedef enum logic [1:0] {IDLE, AR, R} state_t;

    state_t r_state;
    logic   r_grant;
    logic   r_last_grant;
    logic   w_ar;
    logic   w_r;

    // Held in reset every valid/ready output drops, whatever state is still registered
    assign w_ar = rst_n && (r_state == AR);
    assign w_r  = rst_n && (r_state == R);

    assign axi.arvalid = w_ar && (r_grant ? u1.arvalid : u0.arvalid);
    assign axi.araddr  = r_grant ? u1.araddr  : u0.araddr;
    assign axi.arlen   = r_grant ? u1.arlen   : u0.arlen;
    assign axi.arburst = r_grant ? u1.arburst : u0.arburst;
    assign u0.arready  = w_ar && !r_grant && axi.arready;
    assign u1.arready  = w_ar &&  r_grant && axi.arready;

    assign axi.rready  = w_r && (r_grant ? u1.rready : u0.rready);
    assign u0.rvalid   = w_r && !r_grant && axi.rvalid;
    assign u1.rvalid   = w_r &&  r_grant && axi.rvalid;
    assign u0.rresp    = axi.rresp;
    assign u1.rresp    = axi.rresp;
    assign u0.rlast    = axi.rlast;
    assign u1.rlast    = axi.rlast;
    assign u0.rdata    = axi.rdata;
    assign u1.rdata    = axi.rdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            case (r_state)
                IDLE: if (u0.arvalid || u1.arvalid) begin
                    r_grant <= (u0.arvalid && u1.arvalid) ? !r_last_grant : u1.arvalid;
                    r_state <= AR;
                end
                AR: if (axi.arvalid && axi.arready) r_state <= R;
                R: if (axi.rvalid && axi.rready && axi.rlast) begin
                    r_state      <= IDLE;
                    r_last_grant <= r_grant;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
